// File: rtl/datamemory_sized.sv
// Byte-addressed MIPS data memory: byte/half/word loads and stores, alignment/range faults, WAIT_STATES wait cycles.
// Executes WAIT_STATES edges after req is accepted; ready/fault pulse for one cycle; requests arriving in WAIT are ignored.
module datamemory_sized #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0,
  parameter int INIT_TEST   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  req,
  input  logic                  WR_RD,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  output logic                  ready,
  output logic                  fault
);
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [7:0]  WS_M1 = 8'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [31:0] INIT0 = (INIT_TEST != 0) ? 32'd2001 : 32'd0;
  localparam logic [31:0] INIT1 = (INIT_TEST != 0) ? 32'd4001 : 32'd0;
  localparam logic [31:0] INIT2 = (INIT_TEST != 0) ? 32'd5001 : 32'd0;
  localparam logic [31:0] INIT3 = (INIT_TEST != 0) ? 32'd3001 : 32'd0;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  logic [31:0] mem_q [DEPTH] = '{0: INIT0, 1: INIT1, 2: INIT2, 3: INIT3, default: 32'd0};

  state_t                state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic [31:0]           dout_q, dout_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;

  logic                  accept, exec, flt, we;
  logic                  op_ld, op_uns;
  logic [1:0]            op_size;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [31:0]           op_din, rd_word, ld_val, wr_dat;
  logic [3:0]            wr_be;
  logic [IDX_W-1:0]      op_idx;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  always_comb begin
    accept = (state_q == ST_IDLE) && cs && req;

    // In WAIT only the captured request is used; in IDLE the live inputs are.
    if (state_q == ST_WAIT) begin
      op_ld   = wr_rd_q;
      op_size = size_q;
      op_uns  = uns_q;
      op_addr = addr_q;
      op_din  = din_q;
      exec    = (count_q == 8'd0);
    end else begin
      op_ld   = WR_RD;
      op_size = size;
      op_uns  = unsigned_ld;
      op_addr = ADDR;
      op_din  = din;
      exec    = accept && (WAIT_STATES == 0);
    end

    op_idx  = op_addr[IDX_W+1:2];
    rd_word = mem_q[op_idx];
    byte_v  = rd_word[8*op_addr[1:0] +: 8];
    half_v  = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (op_size)
      2'b00:   ld_val = {{24{~op_uns & byte_v[7]}}, byte_v};
      2'b01:   ld_val = {{16{~op_uns & half_v[15]}}, half_v};
      default: ld_val = rd_word;
    endcase

    flt = (op_size == 2'b11)
       || (op_size == 2'b01 && op_addr[0])
       || (op_size == 2'b10 && op_addr[1:0] != 2'b00)
       || (|(op_addr[ADDR_WIDTH-1:2] >> IDX_W));

    case (op_size)
      2'b00: begin
        wr_dat = {4{op_din[7:0]}};
        wr_be  = 4'b0001 << op_addr[1:0];
      end
      2'b01: begin
        wr_dat = {2{op_din[15:0]}};
        wr_be  = op_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_dat = op_din;
        wr_be  = 4'b1111;
      end
    endcase

    // A store pending when rst arrives must never reach the array.
    we = exec && !flt && !op_ld && !rst;

    state_d = state_q;
    count_d = count_q;
    wr_rd_d = wr_rd_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    din_d   = din_q;
    if (accept) begin
      wr_rd_d = WR_RD;
      size_d  = size;
      uns_d   = unsigned_ld;
      addr_d  = ADDR;
      din_d   = din;
      if (WAIT_STATES != 0) begin
        state_d = ST_WAIT;
        count_d = WS_M1;
      end
    end else if (state_q == ST_WAIT) begin
      if (count_q != 8'd0) count_d = count_q - 8'd1;
      else                 state_d = ST_IDLE;
    end

    ready_d = exec;
    fault_d = exec && flt;
    dout_d  = (exec && !flt && op_ld) ? ld_val : dout_q;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[op_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= 8'd0;
      wr_rd_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      dout_q  <= 32'd0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_rd_q <= wr_rd_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign dout  = dout_q;
  assign ready = ready_q;
  assign fault = fault_q;
endmodule

// File: doc/datamemory_sized.md
# datamemory_sized

Byte-addressed, parametrised data memory for the MIPS datapath, successor to the fixed 1 kword word-only memory. It serves MEM-stage loads and stores of byte, halfword and word size with sign or zero extension, byte-lane writes and alignment/range fault detection. It also supports a programmable number of wait states behind a req/ready handshake, so the control FSM can be tested against slow memory.

## Interface
- DEPTH, 1024, number of 32-bit words; must be a power of two, at least 4
- ADDR_WIDTH, 32, byte-address width
- WAIT_STATES, 0, extra cycles per access (0..255)
- INIT_TEST, 1, when 1, words 0..3 preload 2001, 4001, 5001, 3001 at time zero; all other words 0
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cs  in  1  chip select; request ignored when 0
- req  in  1  access request, sampled only in IDLE
- WR_RD  in  1  0 = store, 1 = load (polarity as existing memory)
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_ld  in  1  1 = zero-extend load, 0 = sign-extend
- ADDR  in  ADDR_WIDTH  byte address
- din  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- dout  out  32  load result, registered
- ready  out  1  one-cycle completion pulse
- fault  out  1  one-cycle error pulse, only coincident with ready

## Operation
- Word index = ADDR[ADDR_WIDTH-1:2]; lane = ADDR[1:0]; lane 0 = bits [7:0] (little-endian).
- FSM states: IDLE, WAIT.
- IDLE, cs&req: capture WR_RD, size, unsigned_ld, ADDR and din into request registers.
  - WAIT_STATES=0: execute the access on the same edge; stay in IDLE.
  - Otherwise: count = WAIT_STATES-1, go to WAIT.
- WAIT, count>0: decrement count.
- WAIT, count==0: execute the access from the captured registers on that edge, go to IDLE.
- WAIT ignores req, cs and all inputs; only the captured values are used.
- Execute:
  - Fault conditions: size==11, half with ADDR[0]=1, word with ADDR[1:0]!=0, or word index >= DEPTH.
  - On fault: no array write, dout unchanged, ready=1, fault=1.
  - Otherwise: ready=1, fault=0.
  - Store byte: lane ADDR[1:0] gets din[7:0]; other lanes untouched.
  - Store half: lanes {ADDR[1],0} and {ADDR[1],1} get din[15:0].
  - Store word: all four lanes get din.
  - A store leaves dout unchanged.
  - Load: dout gets the selected byte or half, extended to 32 bits per unsigned_ld. For word loads, unsigned_ld is ignored.
- ready and fault are registered and cleared the following cycle, unless another access executes on that edge.
- Memory contents are not affected by rst. Only INIT_TEST preload defines initial contents.

## Timing
- Reset values: dout=0, ready=0, fault=0, state=IDLE, count=0.
- Let E0 be the edge on which req is sampled in IDLE. The access executes at edge E0+WAIT_STATES. ready/fault are high for the one cycle after that edge.
- Throughput: one access per WAIT_STATES+1 cycles. FSM is back in IDLE during the ready cycle, so a new req may be sampled on the edge that ends the ready cycle.
- Read-after-write: a load accepted after a store's ready cycle returns the stored data. No stale data is allowed.
- rst asserted in WAIT: abort immediately; the pending store is discarded; outputs go to reset values without waiting for a clock.
- rst deasserted: first req can be sampled on the next rising edge.
- req with cs=0: no state change, no ready.

## Test plan
- WAIT_STATES=0, INIT_TEST=1: load word ADDR=0x8 -> dout=5001 (0x1389), ready one cycle after E0, fault=0.
- Store word 0xA1B2C3D4 to 0x10, then SB 0x7F to 0x11, then load word 0x10 -> dout=0xA1B27FD4.
- Same word: load byte 0x13 signed -> 0xFFFFFFA1; unsigned -> 0x000000A1; load half 0x12 signed -> 0xFFFFA1B2.
- Faults: load half 0x11, load word 0x2, size=11, word load at 4*DEPTH -> each ready=fault=1 with dout unchanged; a faulting store to 0x10 leaves the word intact.
- WAIT_STATES=3: load at 0x4 -> ready exactly 4 cycles after E0, dout=4001; req toggled during WAIT is ignored; back-to-back second req accepted on the edge ending the ready cycle.
- WAIT_STATES=3: store 0xDEADBEEF to 0x0, assert rst 1 cycle after E0 -> outputs zero asynchronously; subsequent load of 0x0 returns 2001.
